// File: rtl/semaphore_arbiter.sv
// rtl/semaphore_arbiter.sv - round-robin hardware semaphore bank with per-core TRY/WAIT/RELEASE service
module semaphore_arbiter #(
   parameter int NumberOfSemaphores = 4,
   parameter int NumberOfCores      = 2
) (
   input  logic                                          SEMAPHOREARB_Clk,
   input  logic                                          SEMAPHOREARB_nReset,
   input  logic [NumberOfCores-1:0]                      SEMAPHOREARB_Req_fromCPU,
   input  logic [2*NumberOfCores-1:0]                    SEMAPHOREARB_Op_fromCPU,
   input  logic [8*NumberOfCores-1:0]                    SEMAPHOREARB_Sel_fromCPU,
   output logic [NumberOfCores-1:0]                      SEMAPHOREARB_Ack_toCPU,
   output logic [2*NumberOfCores-1:0]                    SEMAPHOREARB_Status_toCPU,
   output logic [4*NumberOfSemaphores*NumberOfCores-1:0] SEMAPHOREARB_Data_toDecoder,
   output logic [NumberOfSemaphores-1:0]                 SEMAPHOREARB_Locked
);
   localparam int NS = NumberOfSemaphores;
   localparam int NC = NumberOfCores;
   localparam int CW = $clog2(NC);

   localparam logic [1:0] OP_REL  = 2'b01;
   localparam logic [1:0] OP_WAIT = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;
   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_ERR  = 2'b10;

   logic [NS-1:0]    lock_q, lock_d;
   logic [CW-1:0]    owner_q [NS];
   logic [CW-1:0]    owner_d [NS];
   logic [CW-1:0]    ptr_q, ptr_d;
   logic [NC-1:0]    ack_q, ack_d;
   logic [2*NC-1:0]  status_q, status_d;
   logic [NS*NC-1:0] wait_q, wait_d;

   logic [1:0]       op  [NC];
   logic [7:0]       sel [NC];
   logic [NC-1:0]    sel_ok, hit_lock, hit_own, elig;
   logic             gnt_vld;
   logic [CW-1:0]    gnt;
   logic [1:0]       res;

   // Per-core view of the addressed semaphore; out-of-range selects never hit the table
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         op[c]       = SEMAPHOREARB_Op_fromCPU[2*c +: 2];
         sel[c]      = SEMAPHOREARB_Sel_fromCPU[8*c +: 8];
         sel_ok[c]   = 1'b0;
         hit_lock[c] = 1'b0;
         hit_own[c]  = 1'b0;
         for (int s = 0; s < NS; s++) begin
            if (sel[c] == 8'(s)) begin
               sel_ok[c]   = 1'b1;
               hit_lock[c] = lock_q[s];
               hit_own[c]  = (owner_q[s] == CW'(c));
            end
         end
         elig[c] = SEMAPHOREARB_Req_fromCPU[c] & ~ack_q[c]
                 & ~((op[c] == OP_WAIT) & hit_lock[c] & ~hit_own[c]);
      end
   end

   // Two passes: first eligible core at or above the pointer, else lowest eligible below it
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      for (int c = 0; c < NC; c++) begin
         if (!gnt_vld && elig[c] && (CW'(c) >= ptr_q)) begin
            gnt_vld = 1'b1;
            gnt     = CW'(c);
         end
      end
      for (int c = 0; c < NC; c++) begin
         if (!gnt_vld && elig[c]) begin
            gnt_vld = 1'b1;
            gnt     = CW'(c);
         end
      end
   end

   always_comb begin
      lock_d   = lock_q;
      owner_d  = owner_q;
      ack_d    = '0;
      status_d = status_q;
      ptr_d    = ptr_q;
      res      = ST_OK;
      for (int s = 0; s < NS; s++) begin
         for (int c = 0; c < NC; c++) begin
            wait_d[s*NC+c] = SEMAPHOREARB_Req_fromCPU[c] & (op[c] == OP_WAIT) & (sel[c] == 8'(s))
                           & lock_q[s] & (owner_q[s] != CW'(c));
         end
      end
      if (gnt_vld) begin
         ptr_d = (gnt == CW'(NC-1)) ? '0 : gnt + CW'(1);
         for (int c = 0; c < NC; c++) begin
            if (gnt == CW'(c)) begin
               ack_d[c] = 1'b1;
               if (!sel_ok[c] || op[c] == OP_RSVD) begin
                  res = ST_ERR;
               end else if (op[c] == OP_REL) begin
                  res = (hit_lock[c] && hit_own[c]) ? ST_OK : ST_ERR;
                  for (int s = 0; s < NS; s++)
                     if (sel[c] == 8'(s) && hit_lock[c] && hit_own[c]) lock_d[s] = 1'b0;
               end else if (!hit_lock[c]) begin
                  res = ST_OK;
                  for (int s = 0; s < NS; s++) begin
                     if (sel[c] == 8'(s)) begin
                        lock_d[s]  = 1'b1;
                        owner_d[s] = CW'(c);
                     end
                  end
               end else begin
                  res = hit_own[c] ? ST_OK : ST_BUSY;
               end
               status_d[2*c +: 2] = res;
            end
         end
      end
   end

   always_ff @(posedge SEMAPHOREARB_Clk or negedge SEMAPHOREARB_nReset) begin
      if (!SEMAPHOREARB_nReset) begin
         lock_q   <= '0;
         ptr_q    <= '0;
         ack_q    <= '0;
         status_q <= '0;
         wait_q   <= '0;
         for (int s = 0; s < NS; s++) owner_q[s] <= '0;
      end else begin
         lock_q   <= lock_d;
         ptr_q    <= ptr_d;
         ack_q    <= ack_d;
         status_q <= status_d;
         wait_q   <= wait_d;
         for (int s = 0; s < NS; s++) owner_q[s] <= owner_d[s];
      end
   end

   always_comb begin
      for (int s = 0; s < NS; s++) begin
         for (int c = 0; c < NC; c++) begin
            SEMAPHOREARB_Data_toDecoder[(s*NC+c)*4 +: 4] =
               {1'b0, wait_q[s*NC+c], lock_q[s] & (owner_q[s] == CW'(c)), lock_q[s]};
         end
      end
   end

   assign SEMAPHOREARB_Ack_toCPU    = ack_q;
   assign SEMAPHOREARB_Status_toCPU = status_q;
   assign SEMAPHOREARB_Locked       = lock_q;
endmodule

// File: tb/tb_semaphore_arbiter.sv
// tb/tb_semaphore_arbiter.sv - directed scoreboard bench for semaphore_arbiter (4 semaphores, 2 cores)
module tb_semaphore_arbiter;
   localparam logic [1:0] TRY = 2'b00, REL = 2'b01, WT = 2'b10, RSV = 2'b11;
   localparam logic [1:0] OK = 2'b00, BUSY = 2'b01, ERR = 2'b10;

   typedef struct {
      int         core;
      logic [1:0] st;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [3:0]  opv;
   logic [15:0] selv;
   logic [1:0]  ack;
   logic [3:0]  status;
   logic [31:0] data;
   logic [3:0]  locked;

   int   errors = 0;
   int   checks = 0;
   int   lat;
   exp_t sb[$];

   semaphore_arbiter #(.NumberOfSemaphores(4), .NumberOfCores(2)) dut (
      .SEMAPHOREARB_Clk            (clk),
      .SEMAPHOREARB_nReset         (rst_n),
      .SEMAPHOREARB_Req_fromCPU    (req),
      .SEMAPHOREARB_Op_fromCPU     (opv),
      .SEMAPHOREARB_Sel_fromCPU    (selv),
      .SEMAPHOREARB_Ack_toCPU      (ack),
      .SEMAPHOREARB_Status_toCPU   (status),
      .SEMAPHOREARB_Data_toDecoder (data),
      .SEMAPHOREARB_Locked         (locked)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] nib(input int s, input int c);
      return data[(s*2+c)*4 +: 4];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int c, input logic [1:0] op, input logic [7:0] sel);
      req[c]          = 1'b1;
      opv[2*c +: 2]   = op;
      selv[8*c +: 8]  = sel;
   endtask

   task automatic push(input int c, input logic [1:0] st);
      exp_t e;
      e.core = c;
      e.st   = st;
      sb.push_back(e);
   endtask

   // Waits (bounded) for core c's Ack, then pops the scoreboard and compares who acked and the status
   task automatic wait_ack(input int c, input string tag, output int n);
      exp_t e;
      int   who;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack[c] !== 1'b1 && n < 20);
      check({tag, "_ack"}, 64'(ack[c]), 64'(1));
      who = (ack == 2'b01) ? 0 : (ack == 2'b10) ? 1 : -1;
      e = sb.pop_front();
      check({tag, "_core"}, 64'(who), 64'(e.core));
      check({tag, "_st"}, 64'(status[2*e.core +: 2]), 64'(e.st));
      req[c] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      opv   = '0;
      selv  = '0;
      #1;
      check("rst_ack", 64'(ack), 64'(0));
      check("rst_status", 64'(status), 64'(0));
      check("rst_locked", 64'(locked), 64'(0));
      check("rst_data", 64'(data), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // core0 TRY on a free semaphore
      drive(0, TRY, 8'd2);
      push(0, OK);
      wait_ack(0, "t1", lat);
      check("t1_lat", 64'(lat), 64'(1));
      check("t1_locked", 64'(locked), 64'(4'b0100));
      check("t1_nib20", 64'(nib(2, 0)), 64'(4'b0011));
      check("t1_nib21", 64'(nib(2, 1)), 64'(4'b0001));
      @(negedge clk);
      check("t1_pulse", 64'(ack), 64'(0));
      check("t1_hold", 64'(status[1:0]), 64'(OK));

      // core1 TRY on semaphore owned by core0
      drive(1, TRY, 8'd2);
      push(1, BUSY);
      wait_ack(1, "t2", lat);
      check("t2_locked", 64'(locked), 64'(4'b0100));
      check("t2_nib20", 64'(nib(2, 0)), 64'(4'b0011));

      // WAIT blocks until the owner releases, then is granted the following edge
      drive(0, TRY, 8'd1);
      push(0, OK);
      wait_ack(0, "t3a", lat);
      drive(1, WT, 8'd1);
      @(negedge clk);
      @(negedge clk);
      check("t3_noack", 64'(ack), 64'(0));
      check("t3_nib11w", 64'(nib(1, 1)), 64'(4'b0101));
      drive(0, REL, 8'd1);
      push(0, OK);
      push(1, OK);
      wait_ack(0, "t3rel", lat);
      wait_ack(1, "t3wait", lat);
      check("t3_wlat", 64'(lat), 64'(1));
      check("t3_nib11", 64'(nib(1, 1)), 64'(4'b0011));
      check("t3_nib10", 64'(nib(1, 0)), 64'(4'b0001));
      check("t3_locked", 64'(locked), 64'(4'b0110));

      // simultaneous TRYs with Ptr=0: core0 first, core1 one cycle later
      drive(0, TRY, 8'd0);
      drive(1, TRY, 8'd3);
      push(0, OK);
      push(1, OK);
      wait_ack(0, "t4c0", lat);
      check("t4_lat0", 64'(lat), 64'(1));
      wait_ack(1, "t4c1", lat);
      check("t4_lat1", 64'(lat), 64'(1));
      check("t4_locked", 64'(locked), 64'(4'b1111));
      drive(1, REL, 8'd3);
      push(1, OK);
      wait_ack(1, "t4rel", lat);
      check("t4_locked2", 64'(locked), 64'(4'b0111));

      // error cases leave the table untouched
      drive(1, REL, 8'd3);
      push(1, ERR);
      wait_ack(1, "t5rel_free", lat);
      drive(0, TRY, 8'd200);
      push(0, ERR);
      wait_ack(0, "t5range", lat);
      drive(0, RSV, 8'd0);
      push(0, ERR);
      wait_ack(0, "t5rsv", lat);
      drive(1, REL, 8'd2);
      push(1, ERR);
      wait_ack(1, "t5rel_other", lat);
      check("t5_locked", 64'(locked), 64'(4'b0111));
      check("t5_nib20", 64'(nib(2, 0)), 64'(4'b0011));

      // asynchronous reset mid-WAIT
      drive(1, WT, 8'd0);
      @(negedge clk);
      @(negedge clk);
      check("t6_noack", 64'(ack), 64'(0));
      check("t6_nib01w", 64'(nib(0, 1)), 64'(4'b0101));
      #2 rst_n = 1'b0;
      #1;
      check("t6_ack", 64'(ack), 64'(0));
      check("t6_status", 64'(status), 64'(0));
      check("t6_locked", 64'(locked), 64'(0));
      check("t6_data", 64'(data), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push(1, OK);
      wait_ack(1, "t6wait", lat);
      check("t6_lat", 64'(lat), 64'(1));
      check("t6_locked2", 64'(locked), 64'(4'b0001));
      check("t6_nib01", 64'(nib(0, 1)), 64'(4'b0011));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
